pipe_stage_reg: RTL and testbench

Parametrised, flushable pipeline stage register with a valid/ready handshake and an optional skid entry. It generalises the fixed-field, enable-gated inter-stage registers (IF/ID … MEM/WB) to any payload width. Stalls become back-pressure, flushes become synchronous bubble insertion, and the ready path can be registered to break long stall chains. One instance sits between each pair of CPU pipeline stages; payload fields such as D, C, Rd, Wreg and Reg2reg are concatenated by the parent.

---
 rtl/pipe_stage_reg.sv | 75 +++++++
 tb/tb_pipe_stage_reg.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: flushable valid/ready pipeline stage with optional skid entry and registered ready
module pipe_stage_reg #(
    parameter int W          = 71,
    parameter bit SKID       = 1'b1,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic         Clk,
    input  logic         Clr,
    input  logic         Flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);
    typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID_FULL = 2'd2} state_t;
    state_t state_q, state_d;
    logic [W-1:0] main_q, main_d, skid_q, skid_d;
    logic rdy_q, rdy_d, acc, pop;
    logic [W-1:0] bubble;
    assign bubble    = CLEAR_DATA ? '0 : main_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign count     = state_q;
    assign in_ready  = SKID ? rdy_q : (!out_valid || out_ready);
    assign acc       = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                state_d = acc ? FULL : EMPTY;
                main_d  = acc ? in_data : main_q;
            end
            FULL: begin
                if (acc && pop) begin
                    main_d = in_data;
                end else if (acc) begin
                    state_d = SKID_FULL;
                    skid_d  = in_data;
                end else if (pop) begin
                    state_d = EMPTY;
                    main_d  = bubble;
                end
            end
            default: begin
                state_d = pop ? FULL : SKID_FULL;
                main_d  = pop ? skid_q : main_q;
            end
        endcase
        // a flush drops everything, including a payload accepted this cycle
        if (Flush) begin
            state_d = EMPTY;
            main_d  = bubble;
        end
        rdy_d = (state_d != SKID_FULL);
    end
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of skid, combinational-ready and data-holding variants
module tb_pipe_stage_reg;
    logic Clk = 1'b0, Clr = 1'b1, Flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [7:0] in_data = '0;
    logic r0, r1, r2, v0, v1, v2;
    logic [7:0] d0, d1, d2;
    logic [1:0] c0, c1, c2;
    int tests = 0, fails = 0;

    always #5 Clk = ~Clk;

    pipe_stage_reg #(.W(8), .SKID(1'b1), .CLEAR_DATA(1'b1)) u0 (
        .Clk(Clk), .Clr(Clr), .Flush(Flush), .in_valid(in_valid), .in_ready(r0), .in_data(in_data),
        .out_valid(v0), .out_ready(out_ready), .out_data(d0), .count(c0));
    pipe_stage_reg #(.W(8), .SKID(1'b0), .CLEAR_DATA(1'b1)) u1 (
        .Clk(Clk), .Clr(Clr), .Flush(Flush), .in_valid(in_valid), .in_ready(r1), .in_data(in_data),
        .out_valid(v1), .out_ready(out_ready), .out_data(d1), .count(c1));
    pipe_stage_reg #(.W(8), .SKID(1'b1), .CLEAR_DATA(1'b0)) u2 (
        .Clk(Clk), .Clr(Clr), .Flush(Flush), .in_valid(in_valid), .in_ready(r2), .in_data(in_data),
        .out_valid(v2), .out_ready(out_ready), .out_data(d2), .count(c2));

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst_valid", v0, 0);
        chk("rst_data", d0, 0);
        chk("rst_count", c0, 0);
        chk("rst_ready_skid", r0, 1);
        chk("rst_ready_comb", r1, 1);
        chk("rst_data_noclr", d2, 0);
        Clr = 1'b0;
        tick();
        // streaming 0x01..0x10 at full rate
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
            chk("stream_data", d0, i);
            chk("stream_count", c0, 1);
            chk("stream_ready", r0, 1);
            chk("stream_data_comb", d1, i);
        end
        in_valid = 1'b0;
        tick();
        chk("drain_valid", v0, 0);
        chk("drain_clear", d0, 0);
        chk("drain_hold_noclr", d2, 8'h10);
        chk("drain_valid_noclr", v2, 0);
        // stall with skid
        in_valid = 1'b1; in_data = 8'h01; out_ready = 1'b1;
        tick();
        chk("stall_first", d0, 8'h01);
        in_data = 8'h02; out_ready = 1'b0;
        tick();
        chk("stall_count", c0, 2);
        chk("stall_ready", r0, 0);
        chk("stall_hold", d0, 8'h01);
        chk("stall_comb_count", c1, 1);
        in_data = 8'h03;
        tick();
        chk("stall2_count", c0, 2);
        chk("stall2_hold", d0, 8'h01);
        out_ready = 1'b1;
        tick();
        chk("unstall_skid", d0, 8'h02);
        chk("unstall_count", c0, 1);
        chk("unstall_ready", r0, 1);
        tick();
        chk("unstall_third", d0, 8'h03);
        chk("unstall_count3", c0, 1);
        in_valid = 1'b0;
        tick();
        chk("unstall_empty", v0, 0);
        // flush while SKID_FULL
        in_valid = 1'b1; in_data = 8'h0A; out_ready = 1'b0;
        tick();
        in_data = 8'h0B;
        tick();
        chk("pre_flush_count", c0, 2);
        chk("pre_flush_main", d0, 8'h0A);
        Flush = 1'b1; in_data = 8'h0C;
        tick();
        chk("flush_valid", v0, 0);
        chk("flush_count", c0, 0);
        chk("flush_data", d0, 0);
        chk("flush_ready", r0, 1);
        chk("flush_noclr_hold", d2, 8'h0A);
        Flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("post_flush_valid", v0, 0);
        chk("post_flush_comb_valid", v1, 0);
        // flush drops a payload accepted from EMPTY
        in_valid = 1'b1; in_data = 8'h0D; Flush = 1'b1;
        tick();
        chk("flush_acc_valid", v0, 0);
        chk("flush_acc_comb_valid", v1, 0);
        Flush = 1'b0; in_valid = 1'b0;
        // Clr dominates Flush and handshakes
        in_valid = 1'b1; in_data = 8'h66;
        tick();
        chk("pre_clr_data", d2, 8'h66);
        Clr = 1'b1; Flush = 1'b1; in_data = 8'h77;
        tick();
        chk("clr_valid", v0, 0);
        chk("clr_count", c0, 0);
        chk("clr_ready", r0, 1);
        chk("clr_data_noclr", d2, 0);
        chk("clr_valid_comb", v1, 0);
        Clr = 1'b0; Flush = 1'b0;
        tick();
        chk("clr_release_data", d0, 8'h77);
        chk("clr_release_valid", v0, 1);
        in_valid = 1'b0;
        tick();
        // SKID=0 combinational ready
        in_valid = 1'b1; in_data = 8'h33; out_ready = 1'b0;
        tick();
        chk("comb_load", d1, 8'h33);
        in_data = 8'h44;
        #1;
        chk("comb_ready_low", r1, 0);
        out_ready = 1'b1;
        #1;
        chk("comb_ready_high", r1, 1);
        tick();
        chk("comb_replace", d1, 8'h44);
        chk("comb_count", c1, 1);
        in_valid = 1'b0;
        tick();
        chk("comb_empty", v1, 0);
        chk("comb_empty_data", d1, 0);
        // CLEAR_DATA=0 bubble keeps the last payload
        in_valid = 1'b1; in_data = 8'h5A;
        tick();
        chk("bubble_load", d2, 8'h5A);
        in_valid = 1'b0;
        tick();
        chk("bubble_valid", v2, 0);
        chk("bubble_data", d2, 8'h5A);
        chk("bubble_clear_variant", d0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
